calc_n: RTL
===========

CALC_N -- requirements
Module: calc_n

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of independent request ports (1..8).
REQ-002 Parameter DATA_W, default 32: operand/result width; power of two, >= 8.
REQ-003 Parameter QUEUE_DEPTH, default 4: per-port request queue entries (>= 2).
REQ-004 c_clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_cmd_in  input  4*NUM_PORTS  command per port; port i occupies slice [4i:4i+3].
REQ-007 req_data_in  input  DATA_W*NUM_PORTS  operand per port; port i occupies slice [DATA_W*i : DATA_W*i+DATA_W-1].
REQ-008 req_tag_in  input  2*NUM_PORTS  request tag per port, sampled with the command.
REQ-009 out_resp  output  2*NUM_PORTS  per-port response code: 0 none, 1 success, 2 error, 3 dropped.
REQ-010 out_data  output  DATA_W*NUM_PORTS  per-port result; 0 unless out_resp=1.
REQ-011 out_tag  output  2*NUM_PORTS  per-port tag of the request being answered; 0 when out_resp=0.

Function
REQ-012 Each port SHALL run a two-state parser: IDLE and OPERAND2.
REQ-013 In IDLE with cmd != 0, the port SHALL capture cmd, tag and data as op1 and go to OPERAND2; cmd = 0 keeps IDLE.
REQ-014 In OPERAND2, the port SHALL capture data as op2, ignore cmd and tag, attempt enqueue, and return to IDLE.
REQ-015 Enqueue SHALL succeed if the queue holds fewer than QUEUE_DEPTH entries, or holds exactly QUEUE_DEPTH and that queue is popped in the same cycle.
REQ-016 A failed enqueue SHALL set the port's drop-pending flag and store the tag; a later drop while pending SHALL overwrite the stored tag.
REQ-017 A single shared ALU SHALL issue at most one queue head per cycle, chosen round-robin starting after the last granted port; empty queues are skipped.
REQ-018 After reset the round-robin pointer SHALL equal NUM_PORTS-1, so port 0 has first priority.
REQ-019 cmd 1: op1+op2 unsigned; carry-out gives resp 2, data 0; otherwise resp 1 with the sum.
REQ-020 cmd 2: op1-op2 unsigned; op2 > op1 gives resp 2, data 0; otherwise resp 1 with the difference.
REQ-021 cmd 5/6: logical shift left/right of op1 by op2[log2(DATA_W) LSBs]; upper op2 bits are ignored; always resp 1.
REQ-022 All other nonzero cmds SHALL be queued normally and answered with resp 2, data 0, in order.
REQ-023 The result of an issued request SHALL be registered and appear on its port for exactly one cycle, the cycle after issue; outputs SHALL be 0 otherwise.
REQ-024 Uncontended latency: op2 in cycle T gives a response visible in cycle T+2.
REQ-025 Responses within one port SHALL be in request order; each accepted request yields exactly one response.
REQ-026 Drop-pending SHALL be reported as resp 3, data 0, with the stored tag, in the first cycle that port has no ALU result; the flag then clears.
REQ-027 A drop and an ALU result for the same port in the same cycle: the ALU result wins and the drop is delivered later.
REQ-028 A port in OPERAND2 SHALL complete its request regardless of other ports' activity.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL clear all parsers to IDLE, empty all queues, clear drop flags, set the RR pointer to NUM_PORTS-1, and zero out_resp/out_data/out_tag.
REQ-030 Reset mid-operation SHALL discard half-captured, queued and in-flight requests with no response; the first request after reset deasserts needs no idle gap.

Verification (NUM_PORTS=4, DATA_W=32, QUEUE_DEPTH=4)
REQ-031 Port 1: cmd1, tag 2, data 0x0000_0001, then 0x1FFF_FFFF -> at T+2 resp 1, data 0x2000_0000, tag 2, for one cycle only.
REQ-032 Port 0: add 0xFFFF_FFFF+1 -> resp 2, data 0. Sub 1-0xF -> resp 2. cmd 3 -> resp 2. cmd 5 with 0x1 and 0x24 -> resp 1, 0x10. cmd 6 with 0x8000_0000 and 31 -> 0x1.
REQ-033 All 4 ports issue add in the same two cycles -> responses on ports 0,1,2,3 in cycles T+2..T+5, one per cycle.
REQ-034 All 4 ports issue 8 back-to-back requests with distinct tag sequences -> some resp 3; every request answered exactly once; per-port order preserved; no port starved.
REQ-035 Reset asserted in port 2 OPERAND2 with 3 queued entries -> no responses after reset; the next request completes at T+2 with port 0 first in RR.

Source files
------------

// File: rtl/calc_n.sv
// calc_n: per-port two-beat request parsers feeding per-port queues and one shared round-robin ALU.
// Results are registered one cycle after issue; queue overflow is reported later as a per-port drop.
module calc_n #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
  input  logic [2*NUM_PORTS-1:0]      req_tag_in,
  output logic [2*NUM_PORTS-1:0]      out_resp,
  output logic [DATA_W*NUM_PORTS-1:0] out_data,
  output logic [2*NUM_PORTS-1:0]      out_tag
);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int QW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int SHW = $clog2(DATA_W);

  typedef struct packed {
    logic [3:0]        cmd;
    logic [1:0]        tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef enum logic {IDLE = 1'b0, OPERAND2 = 1'b1} state_e;

  req_t                 head     [NUM_PORTS];
  logic [1:0]           drop_tag [NUM_PORTS];
  logic [NUM_PORTS-1:0] q_nonempty;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] drop_rep;

  logic                 grant_vld;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        rr_q, rr_d;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e            state_q, state_d;
    logic [3:0]        cmd_in, cmd_q;
    logic [1:0]        tag_in, tag_q;
    logic [DATA_W-1:0] dat_in, op1_q;
    req_t              mem_q [QUEUE_DEPTH];
    req_t              enq_ent;
    logic [QW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic              enq_try, enq_ok;
    logic              drop_q;
    logic [1:0]        drop_tag_q;

    assign cmd_in = req_cmd_in[4*p +: 4];
    assign tag_in = req_tag_in[2*p +: 2];
    assign dat_in = req_data_in[DATA_W*p +: DATA_W];

    always_ff @(posedge c_clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:     if (cmd_in != 4'd0) state_d = OPERAND2;
        OPERAND2: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end

    always_comb begin
      enq_try = (state_q == OPERAND2);
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        cmd_q <= '0;
        tag_q <= '0;
        op1_q <= '0;
      end else if (state_q == IDLE && cmd_in != 4'd0) begin
        cmd_q <= cmd_in;
        tag_q <= tag_in;
        op1_q <= dat_in;
      end
    end

    // A full queue still accepts when its head leaves in the same cycle.
    assign enq_ok  = enq_try && ((cnt_q < CW'(QUEUE_DEPTH)) || pop[p]);
    assign enq_ent = {cmd_q, tag_q, op1_q, dat_in};

    always_ff @(posedge c_clk) begin
      if (enq_ok) mem_q[wr_q] <= enq_ent;
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (enq_ok) wr_q <= (wr_q == QW'(QUEUE_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (pop[p]) rd_q <= (rd_q == QW'(QUEUE_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        case ({enq_ok, pop[p]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: ;
        endcase
      end
    end

    // A new drop re-arms the flag even in the cycle the previous one is reported.
    always_ff @(posedge c_clk) begin
      if (reset) begin
        drop_q     <= 1'b0;
        drop_tag_q <= '0;
      end else if (enq_try && !enq_ok) begin
        drop_q     <= 1'b1;
        drop_tag_q <= tag_q;
      end else if (drop_rep[p]) begin
        drop_q     <= 1'b0;
      end
    end

    assign drop_rep[p]   = drop_q && !pop[p];
    assign drop_tag[p]   = drop_tag_q;
    assign head[p]       = mem_q[rd_q];
    assign q_nonempty[p] = (cnt_q != '0);
  end

  always_comb begin
    logic [PW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = rr_q;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(rr_q) + k) % NUM_PORTS);
      if (!grant_vld && q_nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int p = 0; p < NUM_PORTS; p++) pop[p] = grant_vld && (grant_idx == PW'(p));
  end

  assign rr_d = grant_vld ? grant_idx : rr_q;

  always_ff @(posedge c_clk) begin
    if (reset) rr_q <= PW'(NUM_PORTS - 1);
    else       rr_q <= rr_d;
  end

  req_t              iss;
  logic [DATA_W:0]   sum;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  always_comb begin
    iss      = head[grant_idx];
    sum      = {1'b0, iss.op1} + {1'b0, iss.op2};
    alu_resp = 2'd2;
    alu_data = '0;
    case (iss.cmd)
      4'd1: if (!sum[DATA_W]) begin
        alu_resp = 2'd1;
        alu_data = sum[DATA_W-1:0];
      end
      4'd2: if (iss.op2 <= iss.op1) begin
        alu_resp = 2'd1;
        alu_data = iss.op1 - iss.op2;
      end
      4'd5: begin
        alu_resp = 2'd1;
        alu_data = iss.op1 << iss.op2[SHW-1:0];
      end
      4'd6: begin
        alu_resp = 2'd1;
        alu_data = iss.op1 >> iss.op2[SHW-1:0];
      end
      default: ;
    endcase
  end

  logic [2*NUM_PORTS-1:0]      out_resp_q;
  logic [DATA_W*NUM_PORTS-1:0] out_data_q;
  logic [2*NUM_PORTS-1:0]      out_tag_q;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp_q <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pop[p]) begin
          out_resp_q[2*p +: 2]           <= alu_resp;
          out_data_q[DATA_W*p +: DATA_W] <= alu_data;
          out_tag_q[2*p +: 2]            <= iss.tag;
        end else if (drop_rep[p]) begin
          out_resp_q[2*p +: 2]           <= 2'd3;
          out_data_q[DATA_W*p +: DATA_W] <= '0;
          out_tag_q[2*p +: 2]            <= drop_tag[p];
        end else begin
          out_resp_q[2*p +: 2]           <= 2'd0;
          out_data_q[DATA_W*p +: DATA_W] <= '0;
          out_tag_q[2*p +: 2]            <= 2'd0;
        end
      end
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;

endmodule
